// File: rtl/gol_pkg.sv
// Shared types for the Game-of-Life generation scheduler: FSM states and
// bank roles, plus the role-to-bank mapping used by the ping-pong swap.
package gol_pkg;

  typedef enum logic [2:0] {
    ST_DRAIN = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_READY = 3'd3,
    ST_RUN   = 3'd4,
    ST_PAUSE = 3'd5
  } sched_state_e;

  // Bank roles expressed as the physical bank index while gen_sel=0.
  localparam logic [1:0] SRC_RD  = 2'd0;
  localparam logic [1:0] SRC_VGA = 2'd1;
  localparam logic [1:0] DST_A   = 2'd2;
  localparam logic [1:0] DST_B   = 2'd3;

  function automatic logic [1:0] bank_of(input logic [1:0] role, input logic gen_sel);
    return {role[1] ^ gen_sel, role[0]};
  endfunction

endpackage

// File: rtl/gen_tick_timer.sv
// Generation period timer: counts while enabled, holds otherwise, and flags a
// tick when the count reaches BASE_PERIOD << shift, restarting from zero.
module gen_tick_timer #(
  parameter int CNT_W       = 31,
  parameter int BASE_PERIOD = 99999
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en_i,
  input  logic       clr_i,
  input  logic [3:0] shift_i,
  output logic       tick_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] period;

  assign period = CNT_W'(BASE_PERIOD) << shift_i;
  assign tick_o = en_i && (cnt_q >= period);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clr_i || tick_o) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/gen_bank_scheduler.sv
// Generation scheduler: sequences drain/clear/load/run phases and arbitrates
// the four ping-pong cell banks between clear, loader, Round engine and VGA.
module gen_bank_scheduler #(
  parameter int ADDR_W      = 24,
  parameter int DATA_W      = 32,
  parameter int CNT_W       = 31,
  parameter int BASE_PERIOD = 99999
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cmd_start,
  input  logic                   cmd_pause,
  input  logic                   cmd_clear,
  input  logic                   cmd_reload,
  input  logic [3:0]             speed_shift,
  input  logic                   clear_done,
  input  logic                   load_done,
  input  logic                   round_busy,
  input  logic [ADDR_W-1:0]      clr_addr,
  input  logic [DATA_W-1:0]      clr_wdata,
  input  logic                   clr_wren,
  input  logic [ADDR_W-1:0]      ld_addr,
  input  logic [DATA_W-1:0]      ld_wdata,
  input  logic                   ld_wren,
  input  logic [ADDR_W-1:0]      rnd_raddr,
  input  logic [ADDR_W-1:0]      rnd_waddr,
  input  logic [DATA_W-1:0]      rnd_wdata,
  input  logic                   rnd_wren,
  input  logic [ADDR_W-1:0]      vga_addr,
  input  logic [3:0][DATA_W-1:0] bank_rdata,
  output logic [3:0][ADDR_W-1:0] bank_addr,
  output logic [3:0][DATA_W-1:0] bank_wdata,
  output logic [3:0]             bank_wren,
  output logic [3:0]             bank_rden,
  output logic [DATA_W-1:0]      rnd_rdata,
  output logic [DATA_W-1:0]      vga_rdata,
  output logic                   clear_start,
  output logic                   load_start,
  output logic                   evo_start,
  output logic                   gen_sel,
  output logic [2:0]             state_o,
  output logic [15:0]            gen_count,
  output logic [7:0]             overrun_cnt
);
  import gol_pkg::*;

  sched_state_e state_q;
  logic         gen_sel_q, load_pend_q, tick_pend_q;
  logic [15:0]  gen_count_q;
  logic [7:0]   overrun_q;
  logic         clear_start_q, load_start_q, evo_start_q;
  logic         gen_sel_d1_q, live_d1_q;
  logic         tick, is_live, go_drain, wr_ok;

  gen_tick_timer #(
    .CNT_W      (CNT_W),
    .BASE_PERIOD(BASE_PERIOD)
  ) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .en_i   (state_q == ST_RUN),
    .clr_i  (state_q == ST_DRAIN),
    .shift_i(speed_shift),
    .tick_o (tick)
  );

  always_comb begin
    is_live  = (state_q == ST_READY) || (state_q == ST_RUN) || (state_q == ST_PAUSE);
    wr_ok    = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    go_drain = is_live && (cmd_clear || (cmd_reload && (state_q != ST_RUN)));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_DRAIN;
      gen_sel_q     <= 1'b0;
      load_pend_q   <= 1'b0;
      tick_pend_q   <= 1'b0;
      gen_count_q   <= '0;
      overrun_q     <= '0;
      clear_start_q <= 1'b0;
      load_start_q  <= 1'b0;
      evo_start_q   <= 1'b0;
      gen_sel_d1_q  <= 1'b0;
      live_d1_q     <= 1'b0;
    end else begin
      clear_start_q <= 1'b0;
      load_start_q  <= 1'b0;
      evo_start_q   <= 1'b0;
      gen_sel_d1_q  <= gen_sel_q;
      live_d1_q     <= is_live;
      if (go_drain) begin
        state_q     <= ST_DRAIN;
        gen_sel_q   <= 1'b0;
        tick_pend_q <= 1'b0;
        gen_count_q <= '0;
        overrun_q   <= '0;
        if (!cmd_clear) load_pend_q <= 1'b1;
      end else begin
        unique case (state_q)
          ST_DRAIN: begin
            if (!round_busy) begin
              clear_start_q <= 1'b1;
              state_q       <= ST_CLEAR;
            end
          end
          ST_CLEAR: begin
            if (clear_done) begin
              if (load_pend_q) begin
                load_start_q <= 1'b1;
                load_pend_q  <= 1'b0;
                state_q      <= ST_LOAD;
              end else begin
                state_q <= ST_READY;
              end
            end
          end
          ST_LOAD: begin
            if (load_done) state_q <= ST_READY;
          end
          ST_READY, ST_PAUSE: begin
            if (cmd_start) state_q <= ST_RUN;
          end
          ST_RUN: begin
            // A tick and a pending tick collapse into a single swap.
            if ((tick || tick_pend_q) && !round_busy) begin
              gen_sel_q   <= ~gen_sel_q;
              evo_start_q <= 1'b1;
              gen_count_q <= gen_count_q + 16'd1;
              tick_pend_q <= 1'b0;
            end else if (tick) begin
              tick_pend_q <= 1'b1;
            end
            if (tick && round_busy && (overrun_q != 8'hFF)) overrun_q <= overrun_q + 8'd1;
            if (cmd_pause) state_q <= ST_PAUSE;
          end
          default: state_q <= ST_DRAIN;
        endcase
      end
    end
  end

  always_comb begin
    bank_addr  = '0;
    bank_wdata = '0;
    bank_wren  = '0;
    bank_rden  = '0;
    if (state_q == ST_CLEAR) begin
      for (int i = 0; i < 4; i++) begin
        bank_addr[i]  = clr_addr;
        bank_wdata[i] = clr_wdata;
        bank_wren[i]  = clr_wren;
      end
    end else if (state_q == ST_LOAD) begin
      for (int i = 0; i < 4; i++) begin
        bank_addr[i]  = ld_addr;
        bank_wdata[i] = ld_wdata;
        bank_wren[i]  = ld_wren;
      end
    end else if (is_live) begin
      bank_addr[bank_of(SRC_RD, gen_sel_q)]  = rnd_raddr;
      bank_rden[bank_of(SRC_RD, gen_sel_q)]  = 1'b1;
      bank_addr[bank_of(SRC_VGA, gen_sel_q)] = vga_addr;
      bank_rden[bank_of(SRC_VGA, gen_sel_q)] = 1'b1;
      bank_addr[bank_of(DST_A, gen_sel_q)]   = rnd_waddr;
      bank_wdata[bank_of(DST_A, gen_sel_q)]  = rnd_wdata;
      bank_wren[bank_of(DST_A, gen_sel_q)]   = rnd_wren && wr_ok;
      bank_addr[bank_of(DST_B, gen_sel_q)]   = rnd_waddr;
      bank_wdata[bank_of(DST_B, gen_sel_q)]  = rnd_wdata;
      bank_wren[bank_of(DST_B, gen_sel_q)]   = rnd_wren && wr_ok;
    end
  end

  // Read data belongs to the address issued one cycle earlier, so select with the delayed mapping.
  assign rnd_rdata = live_d1_q ? bank_rdata[bank_of(SRC_RD, gen_sel_d1_q)] : '0;
  assign vga_rdata = live_d1_q ? bank_rdata[bank_of(SRC_VGA, gen_sel_d1_q)] : '0;

  assign clear_start = clear_start_q;
  assign load_start  = load_start_q;
  assign evo_start   = evo_start_q;
  assign gen_sel     = gen_sel_q;
  assign state_o     = state_q;
  assign gen_count   = gen_count_q;
  assign overrun_cnt = overrun_q;

endmodule

// File: tb/tb_gen_bank_scheduler.sv
// Bench for gen_bank_scheduler: directed phase walk plus random commands, all
// checked every cycle against a rule-level reference model of the scheduler.
module tb_gen_bank_scheduler;
  import gol_pkg::*;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 32;
  localparam int BP     = 9;

  logic                   clk, reset_n;
  logic                   cmd_start, cmd_pause, cmd_clear, cmd_reload;
  logic [3:0]             speed_shift;
  logic                   clear_done, load_done, round_busy;
  logic [ADDR_W-1:0]      clr_addr, ld_addr, rnd_raddr, rnd_waddr, vga_addr;
  logic [DATA_W-1:0]      clr_wdata, ld_wdata, rnd_wdata;
  logic                   clr_wren, ld_wren, rnd_wren;
  logic [3:0][DATA_W-1:0] bank_rdata;
  logic [3:0][ADDR_W-1:0] bank_addr;
  logic [3:0][DATA_W-1:0] bank_wdata;
  logic [3:0]             bank_wren, bank_rden;
  logic [DATA_W-1:0]      rnd_rdata, vga_rdata;
  logic                   clear_start, load_start, evo_start, gen_sel;
  logic [2:0]             state_o;
  logic [15:0]            gen_count;
  logic [7:0]             overrun_cnt;

  gen_bank_scheduler #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(31), .BASE_PERIOD(BP)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_start(cmd_start), .cmd_pause(cmd_pause), .cmd_clear(cmd_clear), .cmd_reload(cmd_reload),
    .speed_shift(speed_shift), .clear_done(clear_done), .load_done(load_done), .round_busy(round_busy),
    .clr_addr(clr_addr), .clr_wdata(clr_wdata), .clr_wren(clr_wren),
    .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_wren(ld_wren),
    .rnd_raddr(rnd_raddr), .rnd_waddr(rnd_waddr), .rnd_wdata(rnd_wdata), .rnd_wren(rnd_wren),
    .vga_addr(vga_addr), .bank_rdata(bank_rdata),
    .bank_addr(bank_addr), .bank_wdata(bank_wdata), .bank_wren(bank_wren), .bank_rden(bank_rden),
    .rnd_rdata(rnd_rdata), .vga_rdata(vga_rdata),
    .clear_start(clear_start), .load_start(load_start), .evo_start(evo_start),
    .gen_sel(gen_sel), .state_o(state_o), .gen_count(gen_count), .overrun_cnt(overrun_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  int cs_seen = 0, ls_seen = 0, es_seen = 0;

  // Reference model state
  sched_state_e m_st;
  logic         m_gsel, m_lpend, m_tpend, m_cs, m_ls, m_es;
  logic [15:0]  m_gcnt;
  int           m_ovr, m_timer;
  logic         m_gsel_prev, m_live_prev;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic live(input sched_state_e s);
    return (s == ST_READY) || (s == ST_RUN) || (s == ST_PAUSE);
  endfunction

  task automatic model_reset();
    m_st = ST_DRAIN; m_gsel = 0; m_lpend = 0; m_tpend = 0;
    m_cs = 0; m_ls = 0; m_es = 0; m_gcnt = 0; m_ovr = 0; m_timer = 0;
    m_gsel_prev = 0; m_live_prev = 0;
  endtask

  task automatic model_drain();
    m_st = ST_DRAIN; m_gsel = 0; m_tpend = 0; m_gcnt = 0; m_ovr = 0; m_timer = 0;
  endtask

  task automatic model_edge();
    int  period;
    bit  tick;
    period = BP << speed_shift;
    m_gsel_prev = m_gsel;
    m_live_prev = live(m_st);
    m_cs = 0; m_ls = 0; m_es = 0;
    case (m_st)
      ST_DRAIN: if (!round_busy) begin m_cs = 1; m_st = ST_CLEAR; end
      ST_CLEAR:
        if (clear_done) begin
          if (m_lpend) begin m_st = ST_LOAD; m_ls = 1; m_lpend = 0; end
          else m_st = ST_READY;
        end
      ST_LOAD: if (load_done) m_st = ST_READY;
      ST_READY, ST_PAUSE: begin
        if (cmd_clear) model_drain();
        else if (cmd_reload) begin m_lpend = 1; model_drain(); end
        else if (cmd_start) m_st = ST_RUN;
      end
      ST_RUN: begin
        if (cmd_clear) model_drain();
        else begin
          tick = (m_timer >= period);
          m_timer = tick ? 0 : m_timer + 1;
          if (tick && round_busy) begin
            m_tpend = 1;
            if (m_ovr < 255) m_ovr++;
          end
          if ((tick || m_tpend) && !round_busy) begin
            m_gsel = ~m_gsel; m_es = 1; m_gcnt = m_gcnt + 16'd1; m_tpend = 0;
          end
          if (cmd_pause) m_st = ST_PAUSE;
        end
      end
      default: m_st = ST_DRAIN;
    endcase
  endtask

  task automatic check_regs();
    check_val("state", state_o, m_st);
    check_val("gen_sel", gen_sel, m_gsel);
    check_val("gen_count", gen_count, m_gcnt);
    check_val("overrun_cnt", overrun_cnt, 8'(m_ovr));
    check_val("clear_start", clear_start, m_cs);
    check_val("load_start", load_start, m_ls);
    check_val("evo_start", evo_start, m_es);
    if (clear_start) cs_seen++;
    if (load_start) ls_seen++;
    if (evo_start) es_seen++;
  endtask

  task automatic check_comb();
    logic [3:0][ADDR_W-1:0] ea;
    logic [3:0][DATA_W-1:0] ed;
    logic [3:0]             ew, er;
    logic [DATA_W-1:0]      erd, evd;
    int s, v;
    ea = '0; ed = '0; ew = '0; er = '0; erd = '0; evd = '0;
    if (m_st == ST_CLEAR || m_st == ST_LOAD) begin
      for (int i = 0; i < 4; i++) begin
        ea[i] = (m_st == ST_CLEAR) ? clr_addr : ld_addr;
        ed[i] = (m_st == ST_CLEAR) ? clr_wdata : ld_wdata;
        ew[i] = (m_st == ST_CLEAR) ? clr_wren : ld_wren;
      end
    end else if (live(m_st)) begin
      s = m_gsel ? 2 : 0;
      v = m_gsel ? 3 : 1;
      ea[s] = rnd_raddr; er[s] = 1'b1;
      ea[v] = vga_addr;  er[v] = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (i != s && i != v) begin
          ea[i] = rnd_waddr;
          ed[i] = rnd_wdata;
          ew[i] = rnd_wren && (m_st != ST_READY);
        end
      end
    end
    if (m_live_prev) begin
      erd = bank_rdata[m_gsel_prev ? 2 : 0];
      evd = bank_rdata[m_gsel_prev ? 3 : 1];
    end
    check_val("bank_addr", bank_addr, ea);
    check_val("bank_wdata", bank_wdata, ed);
    check_val("bank_wren", bank_wren, ew);
    check_val("bank_rden", bank_rden, er);
    check_val("rnd_rdata", rnd_rdata, erd);
    check_val("vga_rdata", vga_rdata, evd);
  endtask

  task automatic rand_data();
    clr_addr  = ADDR_W'($urandom); clr_wdata = $urandom; clr_wren = 1'($urandom_range(0, 1));
    ld_addr   = ADDR_W'($urandom); ld_wdata  = $urandom; ld_wren  = 1'($urandom_range(0, 1));
    rnd_raddr = ADDR_W'($urandom); rnd_waddr = ADDR_W'($urandom);
    rnd_wdata = $urandom; rnd_wren = 1'($urandom_range(0, 1));
    vga_addr  = ADDR_W'($urandom);
    for (int i = 0; i < 4; i++) bank_rdata[i] = $urandom;
  endtask

  task automatic step();
    #1;
    check_comb();
    @(posedge clk);
    model_edge();
    #1;
    check_regs();
  endtask

  task automatic cyc(input logic st, input logic pa, input logic cl, input logic rl,
                     input logic cd, input logic ldn, input logic bsy);
    rand_data();
    cmd_start = st; cmd_pause = pa; cmd_clear = cl; cmd_reload = rl;
    clear_done = cd; load_done = ldn; round_busy = bsy;
    step();
  endtask

  initial begin
    int es0, cs0;
    logic busy_lvl;
    logic [3:0][ADDR_W-1:0] ex12;

    reset_n = 1'b0;
    cmd_start = 0; cmd_pause = 0; cmd_clear = 0; cmd_reload = 0;
    clear_done = 0; load_done = 0; round_busy = 0; speed_shift = 4'd0;
    rand_data();
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check_regs();
    check_comb();
    @(negedge clk);
    reset_n = 1'b1;

    // Clear finishing after ten cycles
    repeat (10) cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    check_val("first_clear_start_cnt", 128'(cs_seen), 128'd1);
    check_val("ready_after_clear", state_o, ST_READY);

    // Reload from READY walks DRAIN, CLEAR, LOAD
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    check_val("in_load", state_o, ST_LOAD);
    rand_data();
    ld_addr = 24'h12;
    cmd_start = 0; cmd_pause = 0; cmd_clear = 0; cmd_reload = 0;
    clear_done = 0; load_done = 0; round_busy = 0;
    #1;
    for (int i = 0; i < 4; i++) ex12[i] = 24'h12;
    check_val("ld_addr_all_banks", bank_addr, ex12);
    step();
    cyc(0, 0, 0, 0, 0, 1, 0);
    check_val("load_start_once", 128'(ls_seen), 128'd1);

    // Free-running generations, period 19 cycles
    speed_shift = 4'd1;
    cyc(1, 0, 0, 0, 0, 0, 0);
    es0 = es_seen;
    repeat (60) cyc(0, 0, 0, 0, 0, 0, 0);
    check_val("evo_in_60", 128'(es_seen - es0), 128'd3);
    check_val("gen_count_3", gen_count, 16'd3);
    check_val("gen_sel_odd", gen_sel, 1'b1);

    // Round engine busy across a tick
    es0 = es_seen;
    repeat (30) cyc(0, 0, 0, 0, 0, 0, 1);
    check_val("no_evo_while_busy", 128'(es_seen - es0), 128'd0);
    check_val("overrun_1", overrun_cnt, 8'd1);
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0);
    check_val("one_late_evo", 128'(es_seen - es0), 128'd1);
    check_val("gen_count_4", gen_count, 16'd4);

    // Pause one cycle before a tick, resume continues the held count
    cyc(0, 1, 0, 0, 0, 0, 0);
    es0 = es_seen;
    repeat (50) cyc(0, 0, 0, 0, 0, 0, 0);
    check_val("no_evo_in_pause", 128'(es_seen - es0), 128'd0);
    check_val("paused", state_o, ST_PAUSE);
    cyc(1, 0, 0, 0, 0, 0, 0);
    check_val("no_evo_on_resume_edge", 128'(es_seen - es0), 128'd0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check_val("evo_after_resume", 128'(es_seen - es0), 128'd1);

    // Clear beats start while Round is busy
    cs0 = cs_seen;
    cyc(1, 0, 1, 0, 0, 0, 1);
    repeat (5) cyc(0, 0, 0, 0, 0, 0, 1);
    check_val("drain_while_busy", state_o, ST_DRAIN);
    check_val("gen_sel_cleared", gen_sel, 1'b0);
    check_val("no_clear_start_busy", 128'(cs_seen - cs0), 128'd0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check_val("clear_start_after_busy", 128'(cs_seen - cs0), 128'd1);

    // Random command traffic
    busy_lvl = 1'b0;
    for (int n = 0; n < 6000; n++) begin
      cyc($urandom_range(0, 5) == 0, $urandom_range(0, 59) == 0, $urandom_range(0, 299) == 0,
          $urandom_range(0, 199) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, busy_lvl);
      if ($urandom_range(0, 24) == 0) busy_lvl = ~busy_lvl;
      if ($urandom_range(0, 499) == 0) speed_shift = 4'($urandom_range(0, 2));
    end

    // Asynchronous reset mid-cycle
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_regs();
    check_comb();
    @(negedge clk);
    reset_n = 1'b1;
    for (int n = 0; n < 40; n++)
      cyc($urandom_range(0, 3) == 0, 0, 0, 0, $urandom_range(0, 4) == 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
